// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: I-cache lookup, decode handshake and execute redirect.
// master = fetch stage, slave = cache/decode/execute side.
interface instr_fetch_if;
    logic [63:0] fetch_pc;
    logic [31:0] instr_reg;
    logic        data_ack;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [63:0] dec_pc;
    logic        dec_ready;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    modport master (
        output fetch_pc,
        input  instr_reg,
        input  data_ack,
        output dec_valid,
        output dec_instr,
        output dec_pc,
        input  dec_ready,
        input  redirect_valid,
        input  redirect_pc
    );

    modport slave (
        input  fetch_pc,
        output instr_reg,
        output data_ack,
        input  dec_valid,
        input  dec_instr,
        input  dec_pc,
        output dec_ready,
        output redirect_valid,
        output redirect_pc
    );
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: owns the fetch PC, queues I-cache hits for decode,
// handles redirects and halts after enqueuing EBREAK.
module instr_fetch #(
    parameter int          QDEPTH    = 2,
    parameter logic [31:0] EBREAK_OP = 32'h0010_0073
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [63:0]         entry_pc,
    instr_fetch_if.master       bus,
    output logic                halted,
    output logic [31:0]         stall_cycles
);
    localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FULL  = 2'd2,
        HALT  = 2'd3
    } state_e;

    state_e          state_q;
    logic [63:0]     fetch_pc_q;
    logic [63:0]     fetch_pc_d;
    logic [63:0]     pc_mem_q  [QDEPTH];
    logic [31:0]     ins_mem_q [QDEPTH];
    logic [AW-1:0]   head_q;
    logic [AW-1:0]   tail_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic            halted_q;
    logic [31:0]     stall_q;
    logic [31:0]     stall_d;

    logic            full;
    logic            pop;
    logic            push;
    logic            unused_ok;

    assign unused_ok = ^{entry_pc[1:0], bus.redirect_pc[1:0]};

    assign full = (count_q == CW'(QDEPTH));
    assign pop  = (count_q != '0) && bus.dec_ready;
    assign push = (state_q == FETCH) && bus.data_ack &&
                  !bus.redirect_valid && (!full || pop);

    always_comb begin
        fetch_pc_d = fetch_pc_q + 64'd4;
        count_d    = count_q + CW'(push) - CW'(pop);
        stall_d    = stall_q;
        if ((state_q == FETCH) && !bus.data_ack && (stall_q != '1))
            stall_d = stall_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= {entry_pc[63:2], 2'b00};
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            halted_q   <= 1'b0;
            stall_q    <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                pc_mem_q[i]  <= '0;
                ins_mem_q[i] <= '0;
            end
        end else begin
            stall_q <= stall_d;
            // Redirect discards any push/pop of this cycle.
            if (bus.redirect_valid && (state_q != IDLE)) begin
                state_q    <= FETCH;
                fetch_pc_q <= {bus.redirect_pc[63:2], 2'b00};
                head_q     <= '0;
                tail_q     <= '0;
                count_q    <= '0;
                halted_q   <= 1'b0;
            end else begin
                count_q <= count_d;
                if (push) begin
                    pc_mem_q[tail_q]  <= fetch_pc_q;
                    ins_mem_q[tail_q] <= bus.instr_reg;
                    tail_q            <= tail_q + 1'b1;
                    fetch_pc_q        <= fetch_pc_d;
                end
                if (pop)
                    head_q <= head_q + 1'b1;
                unique case (state_q)
                    IDLE: state_q <= FETCH;
                    FETCH: begin
                        if (push && (bus.instr_reg == EBREAK_OP)) begin
                            state_q  <= HALT;
                            halted_q <= 1'b1;
                        end else if (full && !pop) begin
                            state_q <= FULL;
                        end
                    end
                    FULL: if (pop) state_q <= FETCH;
                    HALT: state_q <= HALT;
                endcase
            end
        end
    end

    assign bus.fetch_pc  = fetch_pc_q;
    assign bus.dec_valid = (count_q != '0);
    assign bus.dec_pc    = pc_mem_q[head_q];
    assign bus.dec_instr = ins_mem_q[head_q];
    assign halted        = halted_q;
    assign stall_cycles  = stall_q;
endmodule
